alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle operation sequencer that drives the combinational 8-bit `alu` from the issuing side. It accepts 8- or 16-bit operation requests over a valid/ready handshake and steps them through the ALU one byte-pass per cycle, propagating carry and borrow between passes. It assembles the full S/Z/PV/N/C flag byte, owns the architectural F register, and returns results over a second valid/ready handshake. It sits between instruction decode and the register file.

## Interface
- `ALU_W`, 8, ALU operand width; the sequencer supports only 8.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_op` in 5: ALU opcode encoding. ADD=0, SUB=1, AND=2, OR=3, XOR=4, COMPARE=5, SLL=6, SRL=7, SLA=8, SRA=9, ROL=10, ROR=11, INC=12, DEC=13.
- `req_wide` in 1: 16-bit operation.
- `req_a`, `req_b` in 16: operands. Narrow requests use bits [7:0].
- `alu_a`, `alu_b` out 8, `alu_op` out 5: drive the ALU instance.
- `alu_out` in 8, `alu_flags` in 8: ALU result, with C=bit0, N=bit1, PV=bit2.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_result` out 16: result. Narrow results are zero-extended.
- `rsp_flags` out 8: flags for this op. Layout: S=7, Z=6, PV=2, N=1, C=0; bits 5, 4 and 3 are 0.
- `flag_reg` out 8: architectural F register.

## Operation
- States: IDLE, LO, LOFIX (macro only), HI, FIX, RESP.
- `req_ready` = (state==IDLE). An accepted request latches the operands and opcode, then moves to LO.
- LO: drive {a[7:0], b[7:0], op}. Capture `alu_out` to res_lo and capture C, PV and N.
  - Narrow: go to RESP.
  - Wide: go to HI.
- HI, wide ADD/SUB/INC/DEC:
  - Drive {a[15:8], b[15:8]} with ADD, or SUB for SUB/DEC. For INC/DEC, b_hi is forced to 0x00.
  - If the low carry is 1, go to FIX. Otherwise go to RESP.
- HI, wide AND/OR/XOR: drive the high bytes with the same op, then go to RESP.
- Wide with any other op: `req_wide` is ignored and the op executes narrow.
- FIX: drive {res_hi, 0x00, INC} for ADD/INC, or {res_hi, 0x00, DEC} for SUB/DEC. Capture the result into res_hi, then go to RESP.
- Combined flags:
  - C = C_hi | C_fix.
  - PV = PV_hi ^ PV_fix.
  - N comes from the last pass.
  - S = MSB of the full result.
  - Z = (full result == 0).
- ALU PV values are used unmodified.
- F update on the transition into RESP: `flag_reg` ← `rsp_flags`.
  - Exception: wide INC/DEC leave `flag_reg` unchanged, per Z80 INC/DEC rr.
- RESP: hold `rsp_valid`=1 with stable `rsp_result` and `rsp_flags` until `rsp_ready`=1, then go to IDLE.
- `alu_*` are driven to 0 in IDLE and RESP.
- Reset, in any state including mid-op:
  - Next state is IDLE.
  - `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0x00, `flag_reg`=0x00, `alu_*`=0.
  - `req_ready`=1 in the first cycle after reset.

## Timing
- Each ALU pass takes one cycle; the ALU is combinational and its output is captured at the end of the state.
- The request is accepted at edge E0.
- `rsp_valid` rises after:
  - E1: narrow.
  - E2: wide, no carry fix.
  - E3: wide with FIX.
- The macro adds one cycle when LOFIX is taken.
- Minimum response-to-next-accept gap: the RESP-accept edge returns to IDLE, so the next accept occurs at the edge after that.
- No request is accepted while busy, because `req_ready`=0.

## Configuration
- `ALU_SEQ_CARRY_IN_EN` defined:
  - Adds input `req_cin` (1 bit), sampled at accept.
  - With ADD/SUB and `req_cin`=1 and `flag_reg[0]`=1, LO is followed by LOFIX. LOFIX runs INC (ADD) or DEC (SUB) on res_lo.
  - Low carry = C_lo | C_lofix, and PV_lo ^= PV_lofix. This gives ADC/SBC.
- Undefined: no `req_cin` port and no LOFIX state. Carry-in is always 0.

## Test plan
- Narrow ADD 0x7F+0x01 → `rsp_result`=0x0080, `rsp_flags`=0x84. `rsp_valid` rises after E1, and `flag_reg`=0x84.
- Wide ADD 0x00FF+0x0001 → passes LO, HI, FIX. Result 0x0100, flags 0x00, `rsp_valid` after E3.
- Wide SUB 0x1000−0x0001 → passes LO, HI, FIX (DEC). Result 0x0FFF, flags 0x02.
- Wide INC 0xFFFF with `flag_reg`=0x84 preloaded → result 0x0000, `rsp_flags` Z=1. `flag_reg` stays 0x84.
- Hold `rsp_ready`=0 for 3 cycles with `req_valid`=1 → response is stable and `req_ready`=0 throughout. The new request is accepted only after the response completes.
- Assert `reset` during HI → next cycle is IDLE, with `rsp_valid`=0, `flag_reg`=0x00 and `req_ready`=1.
- With the macro: `flag_reg[0]`=1, ADD 0x01+0x01 with `req_cin`=1 → 0x0003, flags 0x00.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps 8/16-bit ops through a combinational 8-bit ALU, assembles S/Z/PV/N/C and owns F.
// Optional ADC/SBC carry-in (req_cin, LOFIX pass) under `ALU_SEQ_CARRY_IN_EN.
module alu_sequencer #(
  parameter int ALU_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic             req_wide,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
`ifdef ALU_SEQ_CARRY_IN_EN
  input  logic             req_cin,
`endif
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [4:0]       alu_op,
  input  logic [ALU_W-1:0] alu_out,
  input  logic [ALU_W-1:0] alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [7:0]       rsp_flags,
  output logic [7:0]       flag_reg
);
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3, OP_XOR = 5'd4;
  localparam logic [4:0] OP_INC = 5'd12, OP_DEC = 5'd13;
`ifdef ALU_SEQ_CARRY_IN_EN
  typedef enum logic [2:0] {IDLE, LO, LOFIX, HI, FIX, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LO, HI, FIX, RESP} state_t;
`endif
  state_t state, nxt;
  logic [15:0] a, b;
  logic [4:0] op;
  logic wide, fc, fpv, fn, fc_d, fpv_d, fn_d;
  logic [7:0] lo, hi, lo_d, hi_d, fl;
  logic sub_like, incdec, arith, unused;
`ifdef ALU_SEQ_CARRY_IN_EN
  logic cin, lofix;
  assign lofix = cin && flag_reg[0] && (op == OP_ADD || op == OP_SUB);
`endif
  assign sub_like = op == OP_SUB || op == OP_DEC;
  assign incdec = op == OP_INC || op == OP_DEC;
  assign arith = op == OP_ADD || op == OP_SUB || incdec;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign fl = {wide ? hi_d[7] : lo_d[7], {hi_d, lo_d} == 16'h0000, 3'b000, fpv_d, fn_d, fc_d};
  assign unused = ^alu_flags[ALU_W-1:3];
  always_comb begin
    nxt = state;
    alu_a = '0;
    alu_b = '0;
    alu_op = '0;
    lo_d = lo;
    hi_d = hi;
    fc_d = fc;
    fpv_d = fpv;
    fn_d = fn;
    case (state)
      IDLE: nxt = req_valid ? LO : IDLE;
      LO: begin
        alu_a = a[7:0];
        alu_b = b[7:0];
        alu_op = op;
        lo_d = alu_out;
        {fpv_d, fn_d, fc_d} = alu_flags[2:0];
`ifdef ALU_SEQ_CARRY_IN_EN
        nxt = lofix ? LOFIX : wide ? HI : RESP;
`else
        nxt = wide ? HI : RESP;
`endif
      end
`ifdef ALU_SEQ_CARRY_IN_EN
      LOFIX: begin
        alu_a = lo;
        alu_op = op == OP_SUB ? OP_DEC : OP_INC;
        lo_d = alu_out;
        fc_d = fc | alu_flags[0];
        fpv_d = fpv ^ alu_flags[2];
        fn_d = alu_flags[1];
        nxt = wide ? HI : RESP;
      end
`endif
      HI: begin
        alu_a = a[15:8];
        alu_b = incdec ? 8'h00 : b[15:8];
        alu_op = arith ? (sub_like ? OP_SUB : OP_ADD) : op;
        hi_d = alu_out;
        {fpv_d, fn_d, fc_d} = alu_flags[2:0];
        nxt = arith && fc ? FIX : RESP;
      end
      FIX: begin
        alu_a = hi;
        alu_op = sub_like ? OP_DEC : OP_INC;
        hi_d = alu_out;
        fc_d = fc | alu_flags[0];
        fpv_d = fpv ^ alu_flags[2];
        fn_d = alu_flags[1];
        nxt = RESP;
      end
      RESP: nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rsp_result <= '0;
      rsp_flags <= '0;
      flag_reg <= '0;
    end else begin
      state <= nxt;
      lo <= lo_d;
      hi <= hi_d;
      fc <= fc_d;
      fpv <= fpv_d;
      fn <= fn_d;
      if (req_valid && req_ready) begin
        a <= req_a;
        b <= req_b;
        op <= req_op;
        hi <= '0;
        wide <= req_wide && (req_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC});
`ifdef ALU_SEQ_CARRY_IN_EN
        cin <= req_cin;
`endif
      end
      // wide INC/DEC behave like Z80 INC/DEC rr and leave F alone
      if (nxt == RESP && state != RESP) begin
        rsp_result <= {hi_d, lo_d};
        rsp_flags <= fl;
        if (!(wide && incdec)) flag_reg <= fl;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_wide, rsp_valid, rsp_ready;
  logic [4:0] req_op, alu_op;
  logic [15:0] req_a, req_b, rsp_result;
  logic [7:0] alu_a, alu_b, alu_out, alu_flags, rsp_flags, flag_reg;
`ifdef ALU_SEQ_CARRY_IN_EN
  logic req_cin;
`endif
  int checks = 0, errors = 0;
  logic [7:0] exp_freg;
  logic [23:0] q_exp[$];
  logic [7:0] q_freg[$];
  int q_lat[$];

  alu_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_wide(req_wide), .req_a(req_a), .req_b(req_b),
`ifdef ALU_SEQ_CARRY_IN_EN
    .req_cin(req_cin),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .flag_reg(flag_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic c, v, n;
    s = '0; r = '0; c = 1'b0; v = 1'b0; n = 1'b0;
    case (op)
      5'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      5'd1, 5'd5: begin
        s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; n = 1'b1;
        v = (a[7] != b[7]) && (r[7] != a[7]);
        if (op == 5'd5) r = a;
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd6, 5'd8: begin r = {a[6:0], 1'b0}; c = a[7]; end
      5'd7: begin r = {1'b0, a[7:1]}; c = a[0]; end
      5'd9: begin r = {a[7], a[7:1]}; c = a[0]; end
      5'd10: begin r = {a[6:0], a[7]}; c = a[7]; end
      5'd11: begin r = {a[0], a[7:1]}; c = a[0]; end
      5'd12: begin r = a + 8'd1; c = a == 8'hFF; v = a == 8'h7F; end
      5'd13: begin r = a - 8'd1; c = a == 8'h00; v = a == 8'h80; n = 1'b1; end
      default: r = '0;
    endcase
    if (op inside {[5'd2:5'd4], [5'd6:5'd11]}) v = ~^r;
    return {5'b0, v, n, c, r};
  endfunction

  assign {alu_flags, alu_out} = alu_f(alu_a, alu_b, alu_op);

  // whole-operand arithmetic reference; {result16, flags8}
  function automatic logic [23:0] ref_op(input logic [15:0] a_in, input logic [15:0] b_in,
                                         input logic [4:0] op, input logic wd, input logic ci);
    logic [15:0] a, b, bb, r;
    logic [16:0] s, one;
    logic [15:0] al;
    logic c, v, n, add;
    int m;
    m = wd ? 15 : 7;
    a = wd ? a_in : {8'h00, a_in[7:0]};
    b = wd ? b_in : {8'h00, b_in[7:0]};
    bb = (op == 5'd12 || op == 5'd13) ? 16'h0000 : b;
    add = op == 5'd0 || op == 5'd12;
    one = {16'h0000, ci | (op == 5'd12) | (op == 5'd13)};
    s = add ? {1'b0, a} + {1'b0, bb} + one : {1'b0, a} - {1'b0, bb} - one;
    c = wd ? s[16] : s[8];
    r = wd ? s[15:0] : {8'h00, s[7:0]};
    n = op == 5'd1 || op == 5'd13;
    v = add ? (a[m] == bb[m]) && (r[m] != a[m]) : (a[m] != bb[m]) && (r[m] != a[m]);
    if (!(op inside {5'd0, 5'd1, 5'd12, 5'd13})) begin
      if (wd) begin
        r = op == 5'd2 ? a & b : op == 5'd3 ? a | b : a ^ b;
        c = 1'b0; n = 1'b0; v = ~^r[15:8];
      end else begin
        al = alu_f(a[7:0], b[7:0], op);
        r = {8'h00, al[7:0]};
        {v, n, c} = al[10:8];
      end
    end
    return {r, r[m], r == 16'h0000, 3'b000, v, n, c};
  endfunction

  task automatic expect_op(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                           input logic w, input logic ci_in);
    logic ci, wd, add, lc;
    logic [7:0] bl;
    logic [8:0] s9;
    logic [23:0] e;
`ifdef ALU_SEQ_CARRY_IN_EN
    ci = ci_in && exp_freg[0] && (op == 5'd0 || op == 5'd1);
    req_cin = ci_in;
`else
    ci = ci_in & 1'b0;
`endif
    wd = w && (op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd12, 5'd13});
    add = op == 5'd0 || op == 5'd12;
    bl = (op == 5'd12 || op == 5'd13) ? 8'h00 : b[7:0];
    s9 = add ? {1'b0, a[7:0]} + {1'b0, bl} + {8'h00, ci | (op == 5'd12) | (op == 5'd13)}
             : {1'b0, a[7:0]} - {1'b0, bl} - {8'h00, ci | (op == 5'd13)};
    lc = s9[8] && (op inside {5'd0, 5'd1, 5'd12, 5'd13});
    e = ref_op(a, b, op, wd, ci);
    q_exp.push_back(e);
    q_lat.push_back(1 + int'(ci) + int'(wd) + int'(wd && lc));
    if (!(wd && (op == 5'd12 || op == 5'd13))) exp_freg = e[7:0];
    q_freg.push_back(exp_freg);
    req_a = a; req_b = b; req_op = op; req_wide = w;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [4:0] op,
                       input logic w, input logic ci);
    int k;
    expect_op(a, b, op, w, ci);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: req_ready=%b required 1", req_ready); end
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input logic rel, output logic [15:0] res);
    int k, lat;
    logic [23:0] e;
    logic [7:0] fr;
    k = 0;
    while (!rsp_valid && k < 12) begin @(negedge clk); k++; end
    e = q_exp.pop_front(); fr = q_freg.pop_front(); lat = q_lat.pop_front();
    res = e[23:8];
    checks += 4;
    if (k != lat) begin errors++; $display("FAIL latency: %0d cycles required %0d", k, lat); end
    if (rsp_result !== e[23:8]) begin errors++; $display("FAIL result: %h required %h", rsp_result, e[23:8]); end
    if (rsp_flags !== e[7:0]) begin errors++; $display("FAIL flags: %h required %h", rsp_flags, e[7:0]); end
    if (flag_reg !== fr) begin errors++; $display("FAIL flag_reg: %h required %h", flag_reg, fr); end
    if (rel) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_drop: rsp_valid=%b required 0", rsp_valid); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_freg = 8'h00;
    checks += 6;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: %b required 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: %b required 0", rsp_valid); end
    if (rsp_result !== 16'h0) begin errors++; $display("FAIL rst_result: %h required 0000", rsp_result); end
    if (rsp_flags !== 8'h0) begin errors++; $display("FAIL rst_flags: %h required 00", rsp_flags); end
    if (flag_reg !== 8'h0) begin errors++; $display("FAIL rst_freg: %h required 00", flag_reg); end
    if ({alu_a, alu_b, alu_op} !== 21'h0) begin errors++; $display("FAIL rst_alu: %h required 0", {alu_a, alu_b, alu_op}); end
  endtask

  task automatic test_narrow;
    logic [15:0] r;
    issue(16'h007F, 16'h0001, 5'd0, 1'b0, 1'b0); collect(1'b1, r);
    checks++;
    if (flag_reg !== 8'h84) begin errors++; $display("FAIL narrow_freg: %h required 84", flag_reg); end
    issue(16'h12AA, 16'h340F, 5'd4, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'h0081, 16'h0000, 5'd7, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'h0010, 16'h0020, 5'd5, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'h0000, 16'h0001, 5'd1, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'h0080, 16'h0055, 5'd13, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'hC3C3, 16'h0000, 5'd6, 1'b1, 1'b0); collect(1'b1, r);
  endtask

  task automatic test_wide;
    logic [15:0] r;
    issue(16'h00FF, 16'h0001, 5'd0, 1'b1, 1'b0); collect(1'b1, r);
    issue(16'h1000, 16'h0001, 5'd1, 1'b1, 1'b0); collect(1'b1, r);
    issue(16'h1234, 16'h0101, 5'd0, 1'b1, 1'b0); collect(1'b1, r);
    issue(16'h8000, 16'h8000, 5'd0, 1'b1, 1'b0); collect(1'b1, r);
    issue(16'hF0F0, 16'h3C3C, 5'd4, 1'b1, 1'b0); collect(1'b1, r);
    issue(16'h0100, 16'h00FF, 5'd3, 1'b1, 1'b0); collect(1'b1, r);
  endtask

  task automatic test_incdec;
    logic [15:0] r;
    issue(16'h007F, 16'h0001, 5'd0, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'hFFFF, 16'h1234, 5'd12, 1'b1, 1'b0); collect(1'b1, r);
    checks += 2;
    if (rsp_flags[6] !== 1'b1) begin errors++; $display("FAIL inc_z: %b required 1", rsp_flags[6]); end
    if (flag_reg !== 8'h84) begin errors++; $display("FAIL inc_freg: %h required 84", flag_reg); end
    issue(16'h0100, 16'h0000, 5'd13, 1'b1, 1'b0); collect(1'b1, r);
  endtask

  task automatic test_random;
    logic [15:0] r;
    repeat (30) begin
      issue(16'($urandom), 16'($urandom), 5'($urandom_range(0, 13)), 1'($urandom), 1'($urandom));
      collect(1'b1, r);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] r1, r2;
    issue(16'h00FF, 16'h0001, 5'd0, 1'b1, 1'b0);
    collect(1'b0, r1);
    expect_op(16'h0033, 16'h000F, 5'd2, 1'b0, 1'b0);
    req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks += 3;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: %b required 1", rsp_valid); end
      if (rsp_result !== r1) begin errors++; $display("FAIL b2b_stable: %h required %h", rsp_result, r1); end
      if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: %b required 0", req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: %b required 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: %b required 0", req_ready); end
    collect(1'b1, r2);
  endtask

  task automatic test_reset_mid;
    issue(16'h1234, 16'h0101, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (alu_a !== 8'h12) begin errors++; $display("FAIL mid_hi: alu_a=%h required 12", alu_a); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q_exp.delete(); q_freg.delete(); q_lat.delete();
    exp_freg = 8'h00;
    checks += 5;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: %b required 1", req_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: %b required 0", rsp_valid); end
    if (flag_reg !== 8'h00) begin errors++; $display("FAIL mid_freg: %h required 00", flag_reg); end
    if (rsp_result !== 16'h0) begin errors++; $display("FAIL mid_result: %h required 0000", rsp_result); end
    if (alu_a !== 8'h00) begin errors++; $display("FAIL mid_alu: %h required 00", alu_a); end
    repeat (4) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: rsp_valid=%b required 0", rsp_valid); end
  endtask

`ifdef ALU_SEQ_CARRY_IN_EN
  task automatic test_carry;
    logic [15:0] r;
    issue(16'h00FF, 16'h0002, 5'd0, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'h0001, 16'h0001, 5'd0, 1'b0, 1'b1); collect(1'b1, r);
    checks++;
    if (rsp_result !== 16'h0003) begin errors++; $display("FAIL adc_result: %h required 0003", rsp_result); end
    issue(16'h00FF, 16'h0002, 5'd0, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'h00FF, 16'h0000, 5'd0, 1'b1, 1'b1); collect(1'b1, r);
    issue(16'h0000, 16'h0001, 5'd1, 1'b0, 1'b0); collect(1'b1, r);
    issue(16'h0100, 16'h0000, 5'd1, 1'b1, 1'b1); collect(1'b1, r);
  endtask
`endif

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_wide = 1'b0; exp_freg = '0;
`ifdef ALU_SEQ_CARRY_IN_EN
    req_cin = 1'b0;
`endif
    test_reset;
    test_narrow;
    test_wide;
    test_incdec;
    test_back_to_back;
    test_random;
    test_reset_mid;
`ifdef ALU_SEQ_CARRY_IN_EN
    test_carry;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
